// File: rtl/corescore_emitter_uart.sv
// 8N1 UART transmitter with a valid/ready byte interface.
// One frame in flight at a time; requests made while busy are dropped.
module corescore_emitter_uart #(
    parameter int unsigned clk_freq_hz = 12000000,
    parameter int unsigned baud_rate   = 115200
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    output logic       o_ready,
    output logic       o_uart_tx
);

    localparam int unsigned DIV = clk_freq_hz / baud_rate;
    localparam int CW = 24;
    localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);
    localparam logic [3:0] LAST_BIT = 4'd9;

    generate
        if (DIV < 2) begin : g_div_check
            $error("corescore_emitter_uart: bit period DIV must be >= 2");
        end
    endgenerate

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [3:0]    bit_cnt;
    logic [3:0]    bit_nx;
    logic [CW-1:0] baud;
    logic [CW-1:0] baud_nx;
    logic [9:0]    shift;
    logic [9:0]    shift_nx;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= IDLE;
            bit_cnt <= '0;
            baud    <= '0;
            shift   <= '1;
        end else begin
            state   <= state_nx;
            bit_cnt <= bit_nx;
            baud    <= baud_nx;
            shift   <= shift_nx;
        end
    end

    // The frame is shifted out LSB first with ones filling in from the
    // top, so the register is all ones again once the stop bit retires.
    always_comb begin
        state_nx = state;
        bit_nx   = bit_cnt;
        baud_nx  = baud;
        shift_nx = shift;
        unique case (state)
            IDLE: begin
                if (i_valid) begin
                    state_nx = SEND;
                    bit_nx   = '0;
                    baud_nx  = RELOAD;
                    shift_nx = {1'b1, i_data, 1'b0};
                end
            end
            SEND: begin
                if (baud == '0) begin
                    if (bit_cnt == LAST_BIT) begin
                        state_nx = IDLE;
                        bit_nx   = '0;
                        shift_nx = '1;
                    end else begin
                        bit_nx   = bit_cnt + 4'd1;
                        baud_nx  = RELOAD;
                        shift_nx = {1'b1, shift[9:1]};
                    end
                end else begin
                    baud_nx = baud - CW'(1);
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign o_ready   = (state == IDLE);
    assign o_uart_tx = shift[0];

endmodule

// File: tb/tb_corescore_emitter_uart.sv
// Directed bench: a slow instance (DIV = 1250) and a fast one (DIV = 4)
// share one clock; frames are checked level-by-level every cycle.
module tb_corescore_emitter_uart;

    logic       clk;
    logic       resetn;
    logic [7:0] data;
    logic       valid;
    logic       sel;
    logic       valid_a;
    logic       valid_b;
    logic       ready_a;
    logic       ready_b;
    logic       tx_a;
    logic       tx_b;
    logic       cur_tx;
    logic       cur_ready;

    int vectors;
    int fails;

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
    } vec_t;

    vec_t vecs[6];

    assign valid_a   = valid & ~sel;
    assign valid_b   = valid & sel;
    assign cur_tx    = sel ? tx_b : tx_a;
    assign cur_ready = sel ? ready_b : ready_a;

    corescore_emitter_uart #(
        .clk_freq_hz(12000000),
        .baud_rate  (9600)
    ) u_slow (
        .clk      (clk),
        .resetn   (resetn),
        .i_data   (data),
        .i_valid  (valid_a),
        .o_ready  (ready_a),
        .o_uart_tx(tx_a)
    );

    corescore_emitter_uart #(
        .clk_freq_hz(48),
        .baud_rate  (12)
    ) u_fast (
        .clk      (clk),
        .resetn   (resetn),
        .i_data   (data),
        .i_valid  (valid_b),
        .o_ready  (ready_b),
        .o_uart_tx(tx_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Called at the negedge of an idle cycle; returns at the negedge of
    // cycle A+1, where A is the accept edge.
    task automatic start(input logic [7:0] d);
        data  = d;
        valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
    endtask

    // Checks cycles A+1 .. A+10*div, then the idle cycle A+10*div+1.
    // With disturb set, i_data is changed and i_valid pulsed mid-frame.
    task automatic check_frame(input string name, input logic [9:0] exp,
                               input int div, input bit disturb);
        int rdy_bad;
        rdy_bad = 0;
        for (int k = 0; k < 10; k++) begin
            int got;
            got = int'(exp[k]);
            for (int c = 0; c < div; c++) begin
                if (cur_tx !== exp[k]) got = int'(cur_tx);
                if (cur_ready !== 1'b0) rdy_bad = 1;
                if (disturb && k == 1 && c == 1) data = 8'h00;
                if (disturb && k == 2 && c == 0) valid = 1'b1;
                if (disturb && k == 2 && c == 1) valid = 1'b0;
                @(negedge clk);
            end
            chk($sformatf("%s bit%0d", name, k), got, int'(exp[k]));
        end
        chk($sformatf("%s ready_low", name), rdy_bad, 0);
        chk($sformatf("%s end_ready", name), int'(cur_ready), 1);
        chk($sformatf("%s end_tx", name), int'(cur_tx), 1);
    endtask

    task automatic check_idle(input string name, input int cycles);
        int bad;
        bad = 0;
        for (int i = 0; i < cycles; i++) begin
            if (cur_tx !== 1'b1 || cur_ready !== 1'b1) bad = 1;
            @(negedge clk);
        end
        chk(name, bad, 0);
    endtask

    initial begin
        vectors = 0;
        fails   = 0;
        vecs[0] = '{8'hA3, 10'b1_10100011_0};
        vecs[1] = '{8'h0F, 10'b1_00001111_0};
        vecs[2] = '{8'h00, 10'b1_00000000_0};
        vecs[3] = '{8'hFF, 10'b1_11111111_0};
        vecs[4] = '{8'h81, 10'b1_10000001_0};
        vecs[5] = '{8'h3C, 10'b1_00111100_0};

        resetn = 1'b0;
        valid  = 1'b1;
        data   = 8'hFF;
        sel    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset ready_slow", int'(ready_a), 1);
        chk("reset tx_slow", int'(tx_a), 1);
        chk("reset ready_fast", int'(ready_b), 1);
        chk("reset tx_fast", int'(tx_b), 1);
        valid  = 1'b0;
        resetn = 1'b1;

        check_idle("idle100", 100);

        start(8'h55);
        check_frame("slow55", 10'b1_01010101_0, 1250, 1'b0);

        sel = 1'b1;
        for (int v = 0; v < 6; v++) begin
            start(vecs[v].data);
            check_frame($sformatf("vec%0d", v), vecs[v].frame, 4, 1'b0);
            check_idle($sformatf("vec%0d gap", v), 2);
        end

        data  = 8'hA3;
        valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        data = 8'h0F;
        check_frame("b2b first", 10'b1_10100011_0, 4, 1'b0);
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        check_frame("b2b second", 10'b1_00001111_0, 4, 1'b0);
        check_idle("b2b after", 8);

        start(8'hFF);
        check_frame("hold", 10'b1_11111111_0, 4, 1'b1);
        check_idle("hold no_second", 12);

        start(8'h00);
        repeat (14) @(negedge clk);
        chk("pre_reset tx", int'(cur_tx), 0);
        resetn = 1'b0;
        valid  = 1'b1;
        data   = 8'h81;
        @(posedge clk);
        @(negedge clk);
        chk("midreset tx", int'(cur_tx), 1);
        chk("midreset ready", int'(cur_ready), 1);
        resetn = 1'b1;
        start(8'h3C);
        check_frame("post_reset", 10'b1_00111100_0, 4, 1'b0);
        check_idle("post_reset idle", 6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/corescore_emitter_uart.md
CORESCORE_EMITTER_UART -- requirements
Module: corescore_emitter_uart

Interface
REQ-001 Parameter clk_freq_hz, default 12000000, frequency of clk in Hz.
REQ-002 Parameter baud_rate, default 115200, serial bit rate in bits/s.
REQ-003 clk  input  1  clock; all state changes on its rising edge.
REQ-004 resetn  input  1  reset, synchronous, active-low.
REQ-005 i_data  input  8  byte to transmit; sampled only at the accept edge.
REQ-006 i_valid  input  1  request to transmit i_data.
REQ-007 o_ready  output  1  high when the block can accept a byte (idle).
REQ-008 o_uart_tx  output  1  serial line, idle high, 8N1 framing.
REQ-009 Reset is resetn, synchronous, active-low; clock is clk.

Function
REQ-010 Bit period DIV SHALL be clk_freq_hz / baud_rate, integer-truncated (12 MHz / 9600 = 1250 cycles).
REQ-011 Elaboration SHALL fail with an error if DIV < 2.
REQ-012 Accept condition SHALL be i_valid and o_ready both high at a rising edge; that edge is the accept edge.
REQ-013 At the accept edge the block SHALL capture i_data internally; later changes to i_data SHALL NOT affect the frame.
REQ-014 Frame SHALL be start bit (0), data bits 0..7 (LSB first), stop bit (1): 10 bits, each exactly DIV cycles.
REQ-015 Timing: o_uart_tx SHALL be 0 from the cycle after the accept edge.
REQ-016 Bit k (k = 0..9, 0 = start) SHALL be driven for cycles A+k*DIV+1 through A+(k+1)*DIV, where A is the accept edge.
REQ-017 o_ready SHALL go low in the cycle after the accept edge and stay low for the whole frame.
REQ-018 o_ready SHALL return high after edge A+10*DIV, when the stop bit ends.
REQ-019 After the frame, o_uart_tx SHALL remain 1 (idle).
REQ-020 i_valid while o_ready is low SHALL be ignored: no queuing, no effect on the current frame.
REQ-021 i_valid held high continuously SHALL produce back-to-back frames with a period of 10*DIV+1 cycles.
REQ-022 Between back-to-back frames the line SHALL be high for exactly 1 cycle.
REQ-023 Idle state (o_ready high) SHALL drive o_uart_tx = 1.
REQ-024 The state SHALL be held as: a bit counter (0..10), a baud down-counter (0..DIV-1) and a 9- or 10-bit shift register.
REQ-025 The baud counter SHALL reload to DIV-1 at the accept edge and at every bit boundary.
REQ-026 Counters SHALL be wide enough for any DIV up to 2^24.
REQ-027 Outputs SHALL be registered: no combinational path from inputs to o_uart_tx or o_ready.

Reset
REQ-028 While resetn is low at a rising edge, after that edge: o_uart_tx = 1, o_ready = 1, counters cleared, shift register set to all ones.
REQ-029 Reset mid-frame SHALL abandon the frame immediately, with no completion of remaining bits.
REQ-030 i_valid SHALL be ignored on any edge where resetn is low.
REQ-031 The first accept SHALL be possible on the first edge with resetn high.

Verification
REQ-032 DIV = 1250, reset then idle 100 cycles -> o_uart_tx = 1 and o_ready = 1 throughout.
REQ-033 DIV = 1250, one-cycle i_valid with 0x55 -> line reads 0,1,0,1,0,1,0,1,0,1, one level per 1250-cycle window sampled mid-bit.
REQ-033 (cont.) o_ready stays low for exactly 12500 cycles, then goes high.
REQ-034 DIV = 4, i_valid held high, data 0xA3 then 0x0F -> frame 0,1,1,0,0,0,1,0,1,1 then 0,1,1,1,1,0,0,0,0,1.
REQ-034 (cont.) Second start bit begins 41 cycles after the first start bit.
REQ-035 DIV = 4, accept 0xFF, change i_data to 0x00 and pulse i_valid during the frame -> frame still carries 0xFF.
REQ-035 (cont.) No second frame follows.
REQ-036 DIV = 4, accept 0x00, assert resetn low at cycle 15 of the frame -> o_uart_tx = 1 and o_ready = 1 after that edge.
REQ-036 (cont.) A new accept on the first edge after reset release starts a full, correct frame.
